// File: rtl/ps2rx_if.sv
// PS/2 receiver bus bundle: the raw keyboard lines and transmitter inhibit
// going in, the received byte and status strobes coming out.
interface ps2rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       inhibit;
   logic [7:0] dout;
   logic       rden;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   // Receiver side: samples the lines, produces byte and status.
   modport slave (
      input  ps2_clk,
      input  ps2_data,
      input  inhibit,
      output dout,
      output rden,
      output parity_err,
      output frame_err,
      output busy
   );

   // Environment side: drives the lines, consumes byte and status.
   modport master (
      output ps2_clk,
      output ps2_data,
      output inhibit,
      input  dout,
      input  rden,
      input  parity_err,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/ps2rx.sv
// Host-side PS/2 device-to-host receiver.
// Synchronises and de-glitches the keyboard clock, samples data on each
// filtered falling edge and assembles start/8 data/odd parity/stop frames.
// Good bytes are delivered with a one-cycle rden strobe; parity, framing and
// inter-edge timeout faults raise one-cycle error strobes. While the local
// transmitter owns the bus (inhibit) the receiver drops to IDLE silently.
module ps2rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 3000,
   parameter int TO_W       = 12
) (
   input  logic   clk,
   input  logic   reset_n,
   ps2rx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

   // Input synchronisers (two flops each)
   logic                  ps2_clk_p0;
   logic                  ps2_clk_p1;
   logic                  ps2_data_p0;
   logic                  ps2_data_p1;

   // Clock glitch filter and edge detect
   logic [FILTER_LEN-1:0] filt_sr_p2;
   logic                  clk_filt_p3;
   logic                  clk_filt_p4;
   logic                  fall_ev;

   // Frame control
   state_t                state;
   state_t                state_nx;
   logic [2:0]            bitcnt;
   logic [7:0]            shreg;
   logic                  par_bit;
   logic [TO_W-1:0]       to_cnt;
   logic                  to_hit;

   // Next-cycle controls decided by the FSM
   logic                  shift_en;
   logic                  par_ld;
   logic                  dout_ld;
   logic                  bit_clr;
   logic                  rden_nx;
   logic                  perr_nx;
   logic                  ferr_nx;

   // Registered outputs
   logic [7:0]            dout_q;
   logic                  rden_q;
   logic                  perr_q;
   logic                  ferr_q;

   // Two-flop synchronisers for the asynchronous PS/2 lines (idle high)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps2_clk_p0  <= 1'b1;
         ps2_clk_p1  <= 1'b1;
         ps2_data_p0 <= 1'b1;
         ps2_data_p1 <= 1'b1;
      end else begin
         ps2_clk_p0  <= bus.ps2_clk;
         ps2_clk_p1  <= ps2_clk_p0;
         ps2_data_p0 <= bus.ps2_data;
         ps2_data_p1 <= ps2_data_p0;
      end
   end

   // Filtered clock only changes level after FILTER_LEN identical samples
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_sr_p2  <= '1;
         clk_filt_p3 <= 1'b1;
         clk_filt_p4 <= 1'b1;
      end else begin
         filt_sr_p2 <= {filt_sr_p2[FILTER_LEN-2:0], ps2_clk_p1};
         if (&filt_sr_p2) begin
            clk_filt_p3 <= 1'b1;
         end else if (~|filt_sr_p2) begin
            clk_filt_p3 <= 1'b0;
         end
         clk_filt_p4 <= clk_filt_p3;
      end
   end

   assign fall_ev = clk_filt_p4 & ~clk_filt_p3;

   // A fall arriving in the same cycle as the limit wins over the timeout
   assign to_hit = (state != IDLE) && (to_cnt == TO_LIMIT);

   // Frame state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and per-edge actions; inhibit overrides everything else
   always_comb begin
      state_nx = state;
      shift_en = 1'b0;
      par_ld   = 1'b0;
      dout_ld  = 1'b0;
      bit_clr  = 1'b0;
      rden_nx  = 1'b0;
      perr_nx  = 1'b0;
      ferr_nx  = 1'b0;
      if (bus.inhibit) begin
         state_nx = IDLE;
      end else if (fall_ev) begin
         case (state)
            IDLE: begin
               // A falling edge with data high is line noise, not a start bit
               if (!ps2_data_p1) begin
                  state_nx = DATA;
                  bit_clr  = 1'b1;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               if (bitcnt == 3'd7) begin
                  state_nx = PARITY;
               end
            end
            PARITY: begin
               par_ld   = 1'b1;
               state_nx = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (!ps2_data_p1) begin
                  ferr_nx = 1'b1;
               end else if ((^shreg) ^ par_bit) begin
                  dout_ld = 1'b1;
                  rden_nx = 1'b1;
               end else begin
                  perr_nx = 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end else if (to_hit) begin
         state_nx = IDLE;
         ferr_nx  = 1'b1;
      end
   end

   // Bit counter, LSB-first shift register and parity capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitcnt  <= 3'd0;
         shreg   <= 8'd0;
         par_bit <= 1'b0;
      end else begin
         if (bit_clr) begin
            bitcnt <= 3'd0;
         end else if (shift_en) begin
            bitcnt <= bitcnt + 3'd1;
         end
         if (shift_en) begin
            shreg <= {ps2_data_p1, shreg[7:1]};
         end
         if (par_ld) begin
            par_bit <= ps2_data_p1;
         end
      end
   end

   // Inter-edge timeout counter: cleared on edges and while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt <= '0;
      end else if (fall_ev || (state == IDLE)) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Output byte and one-cycle status strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= 8'd0;
         rden_q <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         if (dout_ld) begin
            dout_q <= shreg;
         end
         rden_q <= rden_nx;
         perr_q <= perr_nx;
         ferr_q <= ferr_nx;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.rden       = rden_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state != IDLE);

endmodule
